// File: rtl/array_multiplier.sv
// Unsigned 4x4 carry-propagate array multiplier with a registered 8-bit product
// and a valid flag that travels alongside the data.
module array_multiplier (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [7:0] product,
   output logic       out_valid
);

   logic [3:0] pp [4];
   logic [7:0] comb_p;
   logic [3:0] acc;
   logic [3:0] row_sum;
   logic       carry;

   logic [7:0] product_d, product_q;
   logic       out_valid_d, out_valid_q;

   // acc holds the upper bits of the previous row's sum with its carry-out as MSB.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            pp[i][j] = x[j] & y[i];
         end
      end

      comb_p    = '0;
      comb_p[0] = pp[0][0];
      acc       = {1'b0, pp[0][3:1]};
      row_sum   = '0;
      carry     = 1'b0;

      for (int k = 1; k < 4; k++) begin
         // Half adder in the LSB position.
         row_sum[0] = acc[0] ^ pp[k][0];
         carry      = acc[0] & pp[k][0];
         for (int j = 1; j < 4; j++) begin
            row_sum[j] = acc[j] ^ pp[k][j] ^ carry;
            carry      = (acc[j] & pp[k][j]) | (acc[j] & carry) | (pp[k][j] & carry);
         end
         comb_p[k] = row_sum[0];
         acc       = {carry, row_sum[3:1]};
      end

      comb_p[7:4] = acc;
   end

   // Product holds when no valid operands arrive; the flag is a single-cycle pulse.
   always_comb begin
      product_d   = product_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         product_d   = comb_p;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product_q   <= 8'h00;
         out_valid_q <= 1'b0;
      end else begin
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign product   = product_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_multiplier.sv
// Self-checking bench for array_multiplier: directed, boundary, hold, exhaustive,
// randomized and reset scenarios against an arithmetic reference.
module tb_array_multiplier;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] x;
   logic [3:0] y;
   logic [7:0] product;
   logic       out_valid;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   logic [7:0] model_p;

   array_multiplier dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .x         (x),
      .y         (y),
      .product   (product),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [3:0] xa, input logic [3:0] ya);
      @(negedge clk);
      in_valid = v;
      x        = xa;
      y        = ya;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      x        = 4'(($urandom_range(0, 15)));
      y        = 4'(($urandom_range(0, 15)));
      repeat (3) after_edge();
      checks++;
      if (product !== 8'h00 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: product=%0d out_valid=%b, need 0/0", product, out_valid);
      end
      drive(1'b0, 4'd5, 4'd7);
      rst_n = 1'b1;
      after_edge();
      after_edge();
      checks++;
      if (product !== 8'h00 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: product=%0d out_valid=%b, need 0/0", product, out_valid);
      end
      model_p = 8'h00;
   endtask

   task automatic test_directed();
      drive(1'b1, 4'd13, 4'd9);
      after_edge();
      checks++;
      if (product !== 8'd117 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL directed_13x9: product=%0d out_valid=%b, need 117/1", product, out_valid);
      end
      model_p = 8'd117;
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 4'd13, 4'd9);
      after_edge();
      checks++;
      if (product !== 8'd117 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first: product=%0d out_valid=%b, need 117/1", product, out_valid);
      end
      in_valid = 1'b1;
      x        = 4'd14;
      y        = 4'd3;
      after_edge();
      checks++;
      if (product !== 8'd42 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: product=%0d out_valid=%b, need 42/1", product, out_valid);
      end
      model_p = 8'd42;
   endtask

   task automatic test_boundaries();
      logic [3:0] bx [4];
      logic [3:0] by [4];
      logic [7:0] bp [4];
      bx = '{4'd0, 4'd15, 4'd1, 4'd8};
      by = '{4'd15, 4'd15, 4'd15, 4'd8};
      bp = '{8'd0, 8'd225, 8'd15, 8'd64};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, bx[i], by[i]);
         after_edge();
         checks++;
         if (product !== bp[i] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL boundary_%0dx%0d: product=%0d out_valid=%b, need %0d/1",
                     bx[i], by[i], product, out_valid, bp[i]);
         end
      end
      model_p = 8'd64;
   endtask

   task automatic test_hold();
      drive(1'b1, 4'd15, 4'd15);
      after_edge();
      in_valid = 1'b0;
      x        = 4'd3;
      y        = 4'd3;
      after_edge();
      checks++;
      if (product !== 8'd225 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold: product=%0d out_valid=%b, need 225/0", product, out_valid);
      end
      x = 4'bxxxx;
      y = 4'bzzzz;
      after_edge();
      checks++;
      if (product !== 8'd225 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_xz: product=%0d out_valid=%b, need 225/0", product, out_valid);
      end
      model_p = 8'd225;
   endtask

   task automatic test_sweep();
      int bad = 0;
      logic [7:0] e;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x        = 4'(a);
            y        = 4'(b);
            exp_q.push_back(8'(a * b));
            after_edge();
            e = exp_q.pop_front();
            checks++;
            if (product !== e || out_valid !== 1'b1) begin
               errors++;
               bad++;
               if (bad <= 5)
                  $display("FAIL sweep_%0dx%0d: product=%0d out_valid=%b, need %0d/1",
                           a, b, product, out_valid, e);
            end
         end
      end
      model_p = 8'd225;
   endtask

   task automatic test_random();
      logic       v;
      logic [3:0] ra, rb;
      for (int n = 0; n < 60; n++) begin
         v  = 1'($urandom_range(0, 1));
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         if (v) begin
            drive(1'b1, ra, rb);
            model_p = 8'(int'(ra) * int'(rb));
         end else begin
            drive(1'b0, 4'bxxxx, 4'bxxxx);
         end
         after_edge();
         checks++;
         if (product !== model_p || out_valid !== v) begin
            errors++;
            $display("FAIL random_%0d: product=%0d out_valid=%b, need %0d/%b",
                     n, product, out_valid, model_p, v);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 4'd11, 4'd7);
      after_edge();
      in_valid = 1'b1;
      x        = 4'd12;
      y        = 4'd13;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (product !== 8'h00 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: product=%0d out_valid=%b, need 0/0", product, out_valid);
      end
      after_edge();
      checks++;
      if (product !== 8'h00 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_inflight: product=%0d out_valid=%b, need 0/0", product, out_valid);
      end
      drive(1'b0, 4'd12, 4'd13);
      rst_n = 1'b1;
      after_edge();
      checks++;
      if (product !== 8'h00 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_pulse: product=%0d out_valid=%b, need 0/0", product, out_valid);
      end
      drive(1'b1, 4'd12, 4'd13);
      after_edge();
      checks++;
      if (product !== 8'd156 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_recover: product=%0d out_valid=%b, need 156/1", product, out_valid);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      x        = '0;
      y        = '0;
      model_p  = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_boundaries();
      test_hold();
      test_sweep();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
